// File: rtl/match_pkg.sv
// match_pkg
// Shared types and default widths for the match scheduler and the word
// matcher it drives.
//   state_t    - scheduler FSM state (IDLE / LAUNCH / WAIT / RESP), 2 bits
//   word_t     - one vocab word at default widths (WORD_LENGTH*DATA_WIDTH)
//   index_t    - one vocab address at default width (ADDR_WIDTH)
//   ptr_width  - width of a binary requester index (at least 1 bit)
package match_pkg;

  localparam int DEF_ADDR_WIDTH  = 4;
  localparam int DEF_WORD_LENGTH = 3;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_WORD_WIDTH  = DEF_WORD_LENGTH * DEF_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef logic [DEF_WORD_WIDTH-1:0] word_t;
  typedef logic [DEF_ADDR_WIDTH-1:0] index_t;

  // A single requester still needs a 1-bit index so ports never collapse.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/match_scheduler_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin pick: the first asserted request at or
// above ptr, searching upward with wrap-around.
// Ports:
//   req       in   N   request vector
//   ptr       in   PW  search start (must be < N)
//   grant     out  N   one-hot winner (0 when no request)
//   grant_idx out  PW  binary winner (0 when no request)
//   any       out  1   at least one request asserted
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  int          cand;
  logic [PW-1:0] cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 0; off < N; off++) begin
      // ptr < N and off < N, so a single subtraction is enough to wrap.
      cand = int'(ptr) + off;
      if (cand >= N) cand = cand - N;
      cand_idx = PW'(cand);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/match_scheduler.sv
// match_scheduler
// Shares one word matcher between NUM_REQ lookup requesters. Requests are
// round-robin arbitrated; the winner's word is latched and presented to the
// matcher, which is kicked with a one-cycle start pulse. When the matcher
// reports done, found/index are captured and returned to the winner.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is one-hot and only ever asserted for a requester
// whose req_valid is high, so it may be dropped before a transfer without
// side effects. rsp_valid is one-hot, held with stable rsp_found/rsp_index/
// rsp_timeout until rsp_ready of that same requester is high; other rsp_ready
// bits are ignored. Only one transaction is in flight at a time.
//
// Optional feature: define MATCH_TIMEOUT_EN to add a WAIT watchdog that
// returns found=0, index=0, timeout=1 after TIMEOUT_CYCLES cycles without
// done. Without it WAIT waits forever and rsp_timeout is 0.
//
// Ports:
//   clk, rst     single clock, synchronous active-high reset
//   req_valid    in   NUM_REQ  request valid per requester
//   req_ready    out  NUM_REQ  one-hot accept (IDLE only)
//   req_word     in   NUM_REQ*WL*DW  packed words, requester i at slice i
//   rsp_valid    out  NUM_REQ  one-hot response valid
//   rsp_ready    in   NUM_REQ  response accept per requester
//   rsp_found    out  1        match result
//   rsp_index    out  AW       match address (0 when not found)
//   rsp_timeout  out  1        response produced by the watchdog
//   m_start      out  1        one-cycle start pulse to the matcher
//   m_word       out  WL*DW    latched word for the matcher
//   m_done       in   1        matcher done (level)
//   m_found      in   1        matcher found, valid with m_done
//   m_index      in   AW       matcher address, valid with m_done
//   busy         out  1        state != IDLE
//   state_dbg    out  2        current FSM state
module match_scheduler
  import match_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int WORD_LENGTH    = DEF_WORD_LENGTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_REQ-1:0]                         req_valid,
  output logic [NUM_REQ-1:0]                         req_ready,
  input  logic [NUM_REQ*WORD_LENGTH*DATA_WIDTH-1:0]  req_word,
  output logic [NUM_REQ-1:0]                         rsp_valid,
  input  logic [NUM_REQ-1:0]                         rsp_ready,
  output logic                                       rsp_found,
  output logic [ADDR_WIDTH-1:0]                      rsp_index,
  output logic                                       rsp_timeout,
  output logic                                       m_start,
  output logic [WORD_LENGTH*DATA_WIDTH-1:0]          m_word,
  input  logic                                       m_done,
  input  logic                                       m_found,
  input  logic [ADDR_WIDTH-1:0]                      m_index,
  output logic                                       busy,
  output state_t                                     state_dbg
);

  localparam int WW = WORD_LENGTH * DATA_WIDTH;
  localparam int PW = ptr_width(NUM_REQ);

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [PW-1:0]   grant_q, grant_d;
  logic [WW-1:0]   m_word_q, m_word_d;
  logic            found_q, found_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [PW-1:0]      arb_idx;
  logic               arb_any;
  logic [WW-1:0]      sel_word;
  logic               rsp_hs;
  logic [PW-1:0]      rr_next;

`ifdef MATCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
`else
  logic timeout_cfg_unused;
  assign timeout_cfg_unused = (TIMEOUT_CYCLES > 0);
`endif

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Word of the current winner; only consumed in IDLE.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) sel_word = req_word[i*WW +: WW];
    end
  end

  // Response outputs are gated by RESP so they read 0 outside a response.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (state_q == RESP) && (grant_q == PW'(i));
    end
  end

  assign rsp_hs    = |(rsp_valid & rsp_ready);
  assign req_ready = (state_q == IDLE) ? arb_grant : '0;
  assign m_start   = (state_q == LAUNCH);
  assign m_word    = m_word_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;
  assign rsp_found = (state_q == RESP) && found_q;
  assign rsp_index = (state_q == RESP) ? index_q : '0;
`ifdef MATCH_TIMEOUT_EN
  assign rsp_timeout = (state_q == RESP) && timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  // Pointer moves just past the requester that was served.
  always_comb begin
    if (int'(grant_q) >= NUM_REQ - 1) rr_next = '0;
    else                              rr_next = grant_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    grant_d  = grant_q;
    m_word_d = m_word_q;
    found_d  = found_q;
    index_d  = index_q;
`ifdef MATCH_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        // req_ready equals arb_grant here, so arb_any is the handshake.
        if (arb_any) begin
          grant_d  = arb_idx;
          m_word_d = sel_word;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        // m_done may still be high from the previous job; ignore it here.
        state_d = WAIT;
`ifdef MATCH_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      WAIT: begin
        if (m_done) begin
          found_d = m_found;
          index_d = m_found ? m_index : '0;
          state_d = RESP;
`ifdef MATCH_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
`ifdef MATCH_TIMEOUT_EN
        else if (cnt_q == TO_LIMIT) begin
          found_d   = 1'b0;
          index_d   = '0;
          timeout_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_hs) begin
          rr_d    = rr_next;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      grant_q  <= '0;
      m_word_q <= '0;
      found_q  <= 1'b0;
      index_q  <= '0;
`ifdef MATCH_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      m_word_q <= m_word_d;
      found_q  <= found_d;
      index_q  <= index_d;
`ifdef MATCH_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_match_scheduler.sv
// tb_match_scheduler
// Directed bench for match_scheduler. Inputs change 1 time unit after the
// rising edge; the response monitor samples on the falling edge and pops the
// expected queue on every response handshake.
module tb_match_scheduler;
  import match_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int AW      = 4;
  localparam int WL      = 3;
  localparam int DW      = 8;
  localparam int WW      = WL * DW;
  localparam int EW      = 2 + AW + NUM_REQ;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*WW-1:0] req_word;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic                  rsp_found;
  logic [AW-1:0]         rsp_index;
  logic                  rsp_timeout;
  logic                  m_start;
  logic [WW-1:0]         m_word;
  logic                  m_done;
  logic                  m_found;
  logic [AW-1:0]         m_index;
  logic                  busy;
  state_t                state_dbg;

  match_scheduler #(
    .NUM_REQ        (NUM_REQ),
    .ADDR_WIDTH     (AW),
    .WORD_LENGTH    (WL),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_word    (req_word),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_found   (rsp_found),
    .rsp_index   (rsp_index),
    .rsp_timeout (rsp_timeout),
    .m_start     (m_start),
    .m_word      (m_word),
    .m_done      (m_done),
    .m_found     (m_found),
    .m_index     (m_index),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // ---------------- counters / scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_act;
  logic [EW-1:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] rsp_vec(input logic to, input logic fnd,
                                            input logic [AW-1:0] idx,
                                            input logic [NUM_REQ-1:0] who);
    return {to, fnd, idx, who};
  endfunction

  // Monitor: one pop per response handshake.
  always @(negedge clk) begin
    if (!rst && ((rsp_valid & rsp_ready) != '0)) begin
      mon_act = {rsp_timeout, rsp_found, rsp_index, rsp_valid};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got 0x%0h expected no response", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_err++;
          $display("FAIL rsp_payload: got 0x%0h expected 0x%0h", mon_act, mon_exp);
        end
      end
    end
  end

  // ---------------- matcher model ----------------
  bit            mat_auto  = 1'b0;  // index taken from low bits of m_word
  bit            mat_hold  = 1'b0;  // leave done/found/index up after a job
  bit            mat_never = 1'b0;  // never raise done
  int            mat_delay = 0;     // extra WAIT cycles before done
  logic          mat_found = 1'b0;
  logic [AW-1:0] mat_index = '0;

  initial begin
    m_done  = 1'b0;
    m_found = 1'b0;
    m_index = '0;
    forever begin
      @(negedge clk);
      if (m_start) begin
        @(posedge clk); #1;
        if (mat_never) begin
          m_done = 1'b0; m_found = 1'b1; m_index = '1;
        end else begin
          for (int i = 0; i < mat_delay; i++) begin
            // garbage while done is low; it must be ignored
            m_done = 1'b0; m_found = 1'b1; m_index = '1;
            @(posedge clk); #1;
          end
          m_done = 1'b1;
          if (mat_auto) begin
            m_found = 1'b1; m_index = m_word[AW-1:0];
          end else begin
            m_found = mat_found; m_index = mat_index;
          end
          @(posedge clk); #1;
          if (!mat_hold) begin
            m_done = 1'b0; m_found = 1'b0; m_index = '0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(input int budget, output int n);
    n = 0;
    while (rsp_valid == '0 && n < budget) begin
      tick();
      n++;
    end
    if (rsp_valid == '0) begin
      n_vec++; n_err++;
      $display("FAIL wait_rsp: no rsp_valid within %0d cycles", budget);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) begin
      n_vec++; n_err++;
      $display("FAIL wait_idle: still busy after %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [WW-1:0] w_cat;
  int n;

  initial begin
    w_cat     = "cat";
    rst       = 1'b1;
    req_valid = '0;
    req_word  = '0;
    rsp_ready = '1;
    repeat (3) tick();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, IDLE);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_fields", {rsp_found, rsp_index, rsp_timeout}, 0);
    check("rst_m_start", m_start, 0);
    check("rst_m_word", m_word, 0);
    rst = 1'b0;
    tick();

    // 1: single request from requester 1, found at 5
    req_word  = {24'h0, 24'h0, w_cat, 24'h0};
    mat_found = 1'b1; mat_index = 4'd5;
    exp_q.push_back(rsp_vec(1'b0, 1'b1, 4'd5, 4'b0010));
    req_valid = 4'b0010; #1;
    check("t1_req_ready", req_ready, 4'b0010);
    tick(); req_valid = '0;
    check("t1_m_start", m_start, 1);
    check("t1_m_word", m_word, w_cat);
    check("t1_req_ready_busy", req_ready, 0);
    tick();
    check("t1_m_start_pulse", m_start, 0);
    check("t1_busy", busy, 1);
    tick();
    check("t1_rsp_valid", rsp_valid, 4'b0010);
    check("t1_rsp_found", rsp_found, 1);
    check("t1_rsp_index", rsp_index, 5);
    tick();
    check("t1_idle", busy, 0);

    // 2: all four requesting, order 0,1,2,3,0
    do_reset();
    req_word = {24'h40000B, 24'h30000A, 24'h200009, 24'h100008};
    mat_auto = 1'b1;
    exp_q.push_back(rsp_vec(1'b0, 1'b1, 4'h8, 4'b0001));
    exp_q.push_back(rsp_vec(1'b0, 1'b1, 4'h9, 4'b0010));
    exp_q.push_back(rsp_vec(1'b0, 1'b1, 4'hA, 4'b0100));
    exp_q.push_back(rsp_vec(1'b0, 1'b1, 4'hB, 4'b1000));
    exp_q.push_back(rsp_vec(1'b0, 1'b1, 4'h8, 4'b0001));
    req_valid = 4'b1111;
    repeat (17) tick();
    req_valid = '0;
    wait_idle(10);
    check("t2_all_served", exp_q.size(), 0);
    mat_auto = 1'b0;

    // 3: stale done held across LAUNCH (pointer now 1)
    req_word  = {24'h0, 24'h646f67, 24'h0, 24'h0};
    mat_hold  = 1'b1; mat_found = 1'b1; mat_index = 4'd5;
    exp_q.push_back(rsp_vec(1'b0, 1'b1, 4'd5, 4'b0100));
    req_valid = 4'b0100; #1;
    check("t3_req_ready", req_ready, 4'b0100);
    tick(); req_valid = '0;
    wait_idle(10);
    mat_hold = 1'b0; mat_found = 1'b1; mat_index = 4'd12;
    exp_q.push_back(rsp_vec(1'b0, 1'b1, 4'd12, 4'b0100));
    req_valid = 4'b0100;
    tick(); req_valid = '0;
    check("t3_m_start", m_start, 1);
    tick();
    check("t3_no_early_rsp", rsp_valid, 0);
    tick();
    check("t3_rsp_valid", rsp_valid, 4'b0100);
    check("t3_rsp_index", rsp_index, 12);
    wait_idle(10);

    // 4: backpressure, delayed done, not found (pointer now 3)
    req_word  = {24'h0, 24'h0, 24'h78797a, 24'h616263};
    mat_delay = 3; mat_found = 1'b0; mat_index = 4'd7;
    exp_q.push_back(rsp_vec(1'b0, 1'b0, 4'd0, 4'b0001));
    rsp_ready = 4'b1110;
    req_valid = 4'b0011; #1;
    check("t4_req_ready", req_ready, 4'b0001);
    tick(); req_valid = 4'b0010;
    check("t4_m_start", m_start, 1);
    check("t4_no_accept_busy", req_ready, 0);
    wait_rsp(20, n);
    check("t4_latency", n, 5);
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_valid", rsp_valid, 4'b0001);
      check("t4_hold_found", rsp_found, 0);
      check("t4_hold_index", rsp_index, 0);
      check("t4_hold_req_ready", req_ready, 0);
      tick();
    end
    mat_delay = 0; mat_found = 1'b1; mat_index = 4'd3;
    exp_q.push_back(rsp_vec(1'b0, 1'b1, 4'd3, 4'b0010));
    rsp_ready = 4'b0001; #1;
    check("t4_still_valid", rsp_valid, 4'b0001);
    tick();
    check("t4_back_idle", busy, 0);
    check("t4_next_accept", req_ready, 4'b0010);
    rsp_ready = '1;
    tick(); req_valid = '0;
    wait_idle(10);

    // 5: reset while in WAIT (pointer now 2)
    mat_never = 1'b1;
    req_valid = 4'b0010;
    tick(); req_valid = '0;
    tick(); tick();
    check("t5_waiting", state_dbg, WAIT);
    rst = 1'b1;
    tick();
    check("t5_rst_busy", busy, 0);
    check("t5_rst_outputs", {rsp_valid, rsp_found, rsp_index, rsp_timeout, m_start}, 0);
    check("t5_rst_m_word", m_word, 0);
    rst = 1'b0;
    mat_never = 1'b0; mat_found = 1'b1; mat_index = 4'd14;
    req_word  = {24'h7a7a7a, 24'h0, 24'h111111, 24'h0};
    req_valid = 4'b1010; #1;
    check("t5_ptr_zero", req_ready, 4'b0010);
    req_valid = 4'b1000; #1;
    check("t5_req3_grant", req_ready, 4'b1000);
    exp_q.push_back(rsp_vec(1'b0, 1'b1, 4'd14, 4'b1000));
    tick(); req_valid = '0;
    check("t5_m_word", m_word, 24'h7a7a7a);
    wait_idle(10);

    // 6: matcher never answers (pointer now 0)
    mat_never = 1'b1;
    req_word  = {24'h0, 24'h0, 24'h0, 24'h646f67};
`ifdef MATCH_TIMEOUT_EN
    exp_q.push_back(rsp_vec(1'b1, 1'b0, 4'd0, 4'b0001));
    req_valid = 4'b0001;
    tick(); req_valid = '0;
    wait_rsp(40, n);
    check("t6_timeout_latency", n, 9);
    check("t6_timeout_flag", rsp_timeout, 1);
    wait_idle(10);
`else
    req_valid = 4'b0001;
    tick(); req_valid = '0;
    repeat (20) tick();
    check("t6_still_busy", busy, 1);
    check("t6_still_wait", state_dbg, WAIT);
    check("t6_no_rsp", rsp_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_reset_idle", busy, 0);
`endif
    mat_never = 1'b0;

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
